// File: rtl/multi_issue_iq_if.sv
`default_nettype none
// ============================================================================
// multi_issue_iq_if : enqueue/dequeue bundle for the multi-issue instruction queue
// Revision: 1.0
// ============================================================================
interface multi_issue_iq_if #(
   parameter int DEPTH = 16,
   parameter int ENQ_W = 2,
   parameter int DEQ_W = 2
);
   logic [$clog2(ENQ_W+1)-1:0] enq_cnt;
   logic [97*ENQ_W-1:0]        enq_data;
   logic                       enq_ready;
   logic [DEQ_W-1:0]           deq_vld;
   logic [97*DEQ_W-1:0]        deq_data;
   logic [$clog2(DEQ_W+1)-1:0] deq_take;
   logic [$clog2(DEPTH):0]     count;
   logic                       almost_full;

   modport master (
      output enq_cnt, enq_data, deq_take,
      input  enq_ready, deq_vld, deq_data, count, almost_full
   );

   modport slave (
      input  enq_cnt, enq_data, deq_take,
      output enq_ready, deq_vld, deq_data, count, almost_full
   );
endinterface
`default_nettype wire

// File: rtl/multi_issue_iq.sv
`default_nettype none
// ============================================================================
// multi_issue_iq : circular instruction queue, up to ENQ_W in / DEQ_W out per cycle
// Revision: 1.0
// ============================================================================
module multi_issue_iq #(
   parameter int DEPTH  = 16,
   parameter int ENQ_W  = 2,
   parameter int DEQ_W  = 2,
   parameter int AF_LVL = DEPTH - 4
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic         rdy,
   input  wire logic         roll,
   multi_issue_iq_if.slave   bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = 97;
   localparam logic [CNT_W-1:0] C_ENQ_MAX = CNT_W'(ENQ_W);
   localparam logic [CNT_W-1:0] C_DEQ_MAX = CNT_W'(DEQ_W);
   localparam logic [CNT_W-1:0] C_ENQ_LIM = CNT_W'(DEPTH - ENQ_W);
   localparam logic [CNT_W-1:0] C_AF_LVL  = CNT_W'(AF_LVL);

   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] enq_req, take_req, enq_acc, take_eff;
   logic             enq_ready, enq_ok;
   logic [ENQ_W-1:0] wr_en;

   assign enq_ready       = (count_q <= C_ENQ_LIM);
   assign bus.enq_ready   = enq_ready;
   assign bus.count       = count_q;
   assign bus.almost_full = (count_q >= C_AF_LVL);

   // Read lanes come straight from storage; freshly written entries appear next cycle.
   generate
      for (genvar i = 0; i < DEQ_W; i++) begin : g_rd
         assign bus.deq_vld[i]                 = (count_q > CNT_W'(i));
         assign bus.deq_data[ENT_W*i +: ENT_W] = mem_q[head_q + PTR_W'(i)];
      end
   endgenerate

   always_comb begin
      enq_req  = (CNT_W'(bus.enq_cnt) > C_ENQ_MAX) ? C_ENQ_MAX : CNT_W'(bus.enq_cnt);
      take_req = (CNT_W'(bus.deq_take) > C_DEQ_MAX) ? C_DEQ_MAX : CNT_W'(bus.deq_take);
      take_eff = (take_req > count_q) ? count_q : take_req;
      enq_ok   = rdy && !roll && enq_ready;
      enq_acc  = enq_ok ? enq_req : '0;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      if (rdy) begin
         if (roll) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
         end else begin
            head_d  = head_q + PTR_W'(take_eff);
            tail_d  = tail_q + PTR_W'(enq_acc);
            count_d = count_q + enq_acc - take_eff;
         end
      end
      for (int l = 0; l < ENQ_W; l++) begin
         wr_en[l] = enq_ok && (CNT_W'(l) < enq_req);
      end
   end

   always_ff @(posedge clk) begin
      for (int l = 0; l < ENQ_W; l++) begin
         if (wr_en[l]) begin
            mem_q[tail_q + PTR_W'(l)] <= bus.enq_data[ENT_W*l +: ENT_W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_multi_issue_iq.sv
`default_nettype none
// ============================================================================
// tb_multi_issue_iq : table vectors, corner sequences and random traffic vs a queue model
// Revision: 1.0
// ============================================================================
module tb_multi_issue_iq;
   localparam int DEPTH = 8;
   localparam int ENQ_W = 2;
   localparam int DEQ_W = 2;
   localparam int AF    = 4;

   typedef struct {
      bit          rdy;
      bit          roll;
      int          enq;
      logic [31:0] pc;
      int          take;
      int          cnt;
      bit          ready;
      logic [1:0]  vld;
      bit          af;
   } vec_t;

   logic clk, rst, rdy, roll;
   multi_issue_iq_if #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W)) bus ();

   multi_issue_iq #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .AF_LVL(AF)) dut (
      .clk  (clk),
      .rst  (rst),
      .rdy  (rdy),
      .roll (roll),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   logic [96:0] mq [$];
   int n_vec = 0;
   int n_err = 0;

   function automatic logic [96:0] mk(logic [31:0] pc);
      return {pc ^ 32'hA5A5_0000, pc, pc + 32'h100, pc[2]};
   endfunction

   task automatic model_step(bit r, bit rl, int ec, logic [193:0] d, int tk);
      int sz;
      bit acc;
      if (!r) return;
      if (rl) begin
         mq.delete();
         return;
      end
      sz  = mq.size();
      acc = (sz <= DEPTH - ENQ_W);
      if (ec > ENQ_W) ec = ENQ_W;
      if (tk > DEQ_W) tk = DEQ_W;
      if (tk > sz) tk = sz;
      for (int k = 0; k < tk; k++) void'(mq.pop_front());
      if (acc) for (int l = 0; l < ec; l++) mq.push_back(d[97*l +: 97]);
   endtask

   task automatic step(bit r, bit rl, int ec, logic [193:0] d, int tk);
      rdy = r;
      roll = rl;
      bus.enq_cnt  = 2'(ec);
      bus.enq_data = d;
      bus.deq_take = 2'(tk);
      @(posedge clk);
      #1;
      model_step(r, rl, ec, d, tk);
   endtask

   task automatic check(string tag);
      int n = mq.size();
      n_vec++;
      if (bus.count !== 4'(n)) begin
         n_err++;
         $display("FAIL %s count: got %0d want %0d", tag, bus.count, n);
      end
      if (bus.enq_ready !== (n <= DEPTH - ENQ_W)) begin
         n_err++;
         $display("FAIL %s enq_ready: got %b want %b", tag, bus.enq_ready, n <= DEPTH - ENQ_W);
      end
      if (bus.almost_full !== (n >= AF)) begin
         n_err++;
         $display("FAIL %s almost_full: got %b want %b", tag, bus.almost_full, n >= AF);
      end
      for (int i = 0; i < DEQ_W; i++) begin
         if (bus.deq_vld[i] !== (n > i)) begin
            n_err++;
            $display("FAIL %s deq_vld[%0d]: got %b want %b", tag, i, bus.deq_vld[i], n > i);
         end
         if (n > i && bus.deq_data[97*i +: 97] !== mq[i]) begin
            n_err++;
            $display("FAIL %s deq_data[%0d]: got %h want %h", tag, i, bus.deq_data[97*i +: 97], mq[i]);
         end
      end
   endtask

   task automatic check_row(int idx, vec_t v);
      n_vec++;
      if (bus.count !== 4'(v.cnt) || bus.enq_ready !== v.ready ||
          bus.deq_vld !== v.vld || bus.almost_full !== v.af) begin
         n_err++;
         $display("FAIL row%0d: got cnt=%0d rdy=%b vld=%b af=%b want cnt=%0d rdy=%b vld=%b af=%b",
                  idx, bus.count, bus.enq_ready, bus.deq_vld, bus.almost_full,
                  v.cnt, v.ready, v.vld, v.af);
      end
   endtask

   initial begin
      vec_t        tbl [$];
      logic [31:0] pc;
      logic [193:0] d;

      tbl.push_back('{1, 0, 2, 32'h00, 0, 2, 1, 2'b11, 0});
      tbl.push_back('{1, 0, 2, 32'h10, 0, 4, 1, 2'b11, 1});
      tbl.push_back('{1, 0, 2, 32'h20, 0, 6, 1, 2'b11, 1});
      tbl.push_back('{1, 0, 2, 32'h30, 0, 8, 0, 2'b11, 1});
      tbl.push_back('{1, 0, 1, 32'h40, 1, 7, 0, 2'b11, 1});
      tbl.push_back('{1, 0, 0, 32'h00, 3, 5, 1, 2'b11, 1});
      tbl.push_back('{1, 1, 2, 32'h50, 1, 0, 1, 2'b00, 0});
      tbl.push_back('{1, 0, 3, 32'h60, 0, 2, 1, 2'b11, 0});
      tbl.push_back('{0, 0, 2, 32'h70, 2, 2, 1, 2'b11, 0});
      tbl.push_back('{1, 0, 0, 32'h00, 1, 1, 1, 2'b01, 0});
      tbl.push_back('{1, 0, 0, 32'h00, 2, 0, 1, 2'b00, 0});
      tbl.push_back('{1, 0, 2, 32'h80, 0, 2, 1, 2'b11, 0});
      tbl.push_back('{1, 0, 1, 32'h90, 0, 3, 1, 2'b11, 0});
      tbl.push_back('{1, 0, 1, 32'hA0, 0, 4, 1, 2'b11, 1});
      tbl.push_back('{1, 0, 2, 32'hB0, 2, 4, 1, 2'b11, 1});

      clk = 0;
      rst = 1;
      rdy = 0;
      roll = 0;
      bus.enq_cnt  = '0;
      bus.enq_data = '0;
      bus.deq_take = '0;
      #3;
      check("reset");
      @(negedge clk);
      rst = 0;

      foreach (tbl[i]) begin
         step(tbl[i].rdy, tbl[i].roll, tbl[i].enq,
              {mk(tbl[i].pc + 32'h4), mk(tbl[i].pc)}, tbl[i].take);
         check_row(i, tbl[i]);
         check($sformatf("row%0d", i));
      end

      // Steady two-in two-out stream long enough to wrap both pointers.
      pc = 32'h1000;
      for (int k = 0; k < 20; k++) begin
         step(1, 0, 2, {mk(pc + 32'h4), mk(pc)}, 2);
         pc += 32'h8;
         check($sformatf("stream%0d", k));
      end

      #2;
      rst = 1;
      #1;
      mq.delete();
      check("async_rst");
      @(negedge clk);
      rst = 0;
      step(1, 0, 1, {mk(32'h0), mk(32'h2000)}, 0);
      check("post_rst");

      for (int k = 0; k < 400; k++) begin
         d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3))};
         step($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0, $urandom_range(0, 3), d,
              (k < 200) ? $urandom_range(0, 1) : $urandom_range(0, 3));
         check($sformatf("rand%0d", k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/multi_issue_iq.md
MULTI_ISSUE_IQ -- requirements
Module: multi_issue_iq

Interface
REQ-001 Parameter DEPTH, 16, number of entries; power of two, >= 4.
REQ-002 Parameter ENQ_W, 2, maximum instructions written per cycle, 1..2.
REQ-003 Parameter DEQ_W, 2, maximum instructions read per cycle, 1..2.
REQ-004 Parameter AF_LVL, DEPTH-4, almost-full threshold in entries.
REQ-005 Entry payload SHALL be inst[31:0], pc[31:0], btb_pc[31:0], btb_pred[0] (97 bits); lane i occupies bits [97*i +: 97] of each packed bus.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset; asynchronous, active-high.
REQ-008 rdy  in  1  global enable; low freezes all state.
REQ-009 roll  in  1  synchronous flush on branch mispredict.
REQ-010 enq_cnt  in  $clog2(ENQ_W+1)  number of lanes offered this cycle (lanes 0..enq_cnt-1).
REQ-011 enq_data  in  97*ENQ_W  packed enqueue payload.
REQ-012 enq_ready  out  1  queue can accept ENQ_W entries this cycle.
REQ-013 deq_vld  out  DEQ_W  bit i high when entry head+i is present.
REQ-014 deq_data  out  97*DEQ_W  packed payload of entries head..head+DEQ_W-1.
REQ-015 deq_take  in  $clog2(DEQ_W+1)  number of entries consumed this cycle.
REQ-016 count  out  $clog2(DEPTH)+1  current occupancy.
REQ-017 almost_full  out  1  count >= AF_LVL.

Function
REQ-018 Storage SHALL be a circular buffer with head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH and a separate occupancy counter.
REQ-019 enq_ready, deq_vld, deq_data, almost_full SHALL be combinational from current registered state only (no same-cycle bypass of enq_data to deq_data).
REQ-020 enq_ready SHALL equal (count <= DEPTH-ENQ_W); dequeue in the same cycle SHALL NOT raise it.
REQ-021 Enqueue SHALL be all-or-nothing: when enq_ready && enq_cnt>0, lanes 0..enq_cnt-1 written to tail..tail+enq_cnt-1 and tail advances by enq_cnt; when !enq_ready nothing is written.
REQ-022 deq_vld[i] SHALL equal (count > i); deq_data lane i SHALL be entry (head+i) mod DEPTH, don't-care when deq_vld[i] low.
REQ-023 Effective take SHALL be min(deq_take, count); head advances by effective take; over-request is clamped, never underflows.
REQ-024 count_next SHALL be count + accepted_enq - effective_take, computed at full counter width, same cycle.
REQ-025 Simultaneous enqueue and dequeue SHALL both take effect; entries written this cycle are visible at deq_data from the next cycle.
REQ-026 Order SHALL be preserved: entries leave in exactly the order written, lane 0 before lane 1 within a cycle.
REQ-027 roll high (with rdy high) SHALL set head, tail, count to 0 next cycle, discarding same-cycle enqueue and take; roll has priority over all other updates.
REQ-028 rdy low SHALL hold all state; enq and take ignored; outputs continue to reflect held state.
REQ-029 enq_cnt > ENQ_W or deq_take > DEQ_W SHALL be clamped to the maximum.

Reset
REQ-030 On rst high, asynchronously: head=0, tail=0, count=0; hence enq_ready=1, deq_vld=0, almost_full=0; payload RAM not reset.
REQ-031 rst asserted mid-operation SHALL discard all entries immediately; first enqueue after deassertion lands at index 0.

Verification (DEPTH=8, ENQ_W=2, DEQ_W=2, AF_LVL=4)
REQ-032 Reset then enq_cnt=2 of pc 0x0,0x4 -> next cycle count=2, deq_vld=2'b11, lane0 pc=0x0, lane1 pc=0x4.
REQ-033 Fill to count=6, enq_cnt=2 -> accepted, count=8, enq_ready=0; further enq_cnt=1 with deq_take=1 -> enqueue rejected, count=7.
REQ-034 count=1, deq_take=2 -> take clamped to 1, count=0, deq_vld=0.
REQ-035 Enqueue/dequeue 2 per cycle for 20 cycles -> pointers wrap, pc sequence out equals sequence in, count steady.
REQ-036 count=5, roll=1 with enq_cnt=2 -> next cycle count=0, enq_ready=1; rdy=0 with enq_cnt=2 -> count unchanged.
REQ-037 count=3 then enqueue 1 -> almost_full rises at count=4; async rst mid-cycle -> count=0 before next edge.
